universal_shift_reg: RTL

Parametrised register of master-slave D flip-flops with synchronous reset and eight operating modes: hold, parallel load, shift and rotate in both directions, clear, and an autonomous burst serializer. It generalises the single-bit D flip-flop stage to a WIDTH-bit register. The serializer mode adds a counter-driven state machine with Busy and Done handshakes. It sits between switch inputs and LED/serial outputs on the lab board top level.

---
 rtl/universal_shift_reg_if.sv | 24 ++
 rtl/universal_shift_reg.sv | 98 +++++++++
 2 files changed

// File: rtl/universal_shift_reg_if.sv
// Bus bundle for universal_shift_reg: control/data in, register state out.
interface universal_shift_reg_if #(
   parameter int WIDTH = 8
);
   logic             En;
   logic [2:0]       Mode;
   logic [WIDTH-1:0] D;
   logic             SerIn;
   logic [WIDTH-1:0] Q;
   logic             SerOut;
   logic             Busy;
   logic             Done;
   logic             Parity;

   modport master (
      output En, Mode, D, SerIn,
      input  Q, SerOut, Busy, Done, Parity
   );

   modport slave (
      input  En, Mode, D, SerIn,
      output Q, SerOut, Busy, Done, Parity
   );
endinterface

// File: rtl/universal_shift_reg.sv
// WIDTH-bit universal shift register with burst serializer.
// Optional macro USR_PARITY_EN enables the Parity XOR tree.
module universal_shift_reg #(
   parameter int WIDTH = 8
) (
   input logic                  Clk,
   input logic                  Reset,
   universal_shift_reg_if.slave bus
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic {
      IDLE,
      SHIFT
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= IDLE;
         q_q     <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         q_q     <= q_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      q_d     = q_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      if (bus.En) begin
         unique case (state_q)
            IDLE: begin
               unique case (bus.Mode)
                  3'b000: q_d = q_q;
                  3'b001: q_d = bus.D;
                  3'b010: q_d = {q_q[WIDTH-2:0], bus.SerIn};
                  3'b011: q_d = {bus.SerIn, q_q[WIDTH-1:1]};
                  3'b100: q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                  3'b101: q_d = {q_q[0], q_q[WIDTH-1:1]};
                  3'b110: begin
                     q_d     = bus.D;
                     cnt_d   = '0;
                     state_d = SHIFT;
                     busy_d  = 1'b1;
                  end
                  3'b111: q_d = '0;
                  default: q_d = q_q;
               endcase
            end
            SHIFT: begin
               // Only clear is honoured mid-burst; it aborts without Done.
               if (bus.Mode == 3'b111) begin
                  q_d     = '0;
                  state_d = IDLE;
                  busy_d  = 1'b0;
               end else begin
                  q_d   = {bus.SerIn, q_q[WIDTH-1:1]};
                  cnt_d = cnt_q + 1'b1;
                  if (cnt_q == LAST) begin
                     state_d = IDLE;
                     busy_d  = 1'b0;
                     done_d  = 1'b1;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign bus.Q      = q_q;
   assign bus.SerOut = q_q[0];
   assign bus.Busy   = busy_q;
   assign bus.Done   = done_q;

`ifdef USR_PARITY_EN
   assign bus.Parity = ^q_q;
`else
   assign bus.Parity = 1'b0;
`endif

endmodule
